// File: rtl/pwm_dac.sv
// First-order PWM DAC: a free-running WIDTH-bit counter compared against a
// double-buffered duty value that only changes at period boundaries.
module pwm_dac #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             underrun_clr,
  output logic             pwm_out,
  output logic             period_tick,
  output logic             underrun
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;
  logic             r_full;
  logic             r_pwm;
  logic             r_tick;
  logic             r_underrun;

  logic w_xfer;
  logic w_boundary;
  logic w_underrun_set;

  assign sample_ready   = !r_full && !rst;
  assign w_xfer         = sample_valid && sample_ready;
  assign w_boundary     = en && (r_cnt == CNT_MAX);
  // A sample arriving exactly on the boundary bypasses the shadow register.
  assign w_underrun_set = w_boundary && !r_full && !w_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_shadow   <= '0;
      r_active   <= '0;
      r_full     <= 1'b0;
      r_pwm      <= 1'b0;
      r_tick     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (en) begin
        r_cnt <= r_cnt + 1'b1;
        r_pwm <= (r_cnt < r_active);
      end else begin
        r_pwm <= 1'b0;
      end

      r_tick <= w_boundary;

      if (w_boundary) begin
        if (r_full) begin
          r_active <= r_shadow;
          r_full   <= 1'b0;
        end else if (w_xfer) begin
          r_active <= sample_in;
        end
      end else if (w_xfer) begin
        r_shadow <= sample_in;
        r_full   <= 1'b1;
      end

      if (w_underrun_set) begin
        r_underrun <= 1'b1;
      end else if (underrun_clr) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign pwm_out     = r_pwm;
  assign period_tick = r_tick;
  assign underrun    = r_underrun;

endmodule

// File: doc/pwm_dac.md
PWM_DAC -- requirements
Module: pwm_dac

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the sample width; the PWM period is 2^WIDTH clk cycles.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port en  input  1  modulator run enable.
REQ-005 SHALL have port sample_in  input  WIDTH  unsigned sample (DDS Magnitude).
REQ-006 SHALL have port sample_valid  input  1  sample_in valid this cycle.
REQ-007 SHALL have port sample_ready  output  1  shadow register can accept a sample.
REQ-008 SHALL have port underrun_clr  input  1  clears the underrun flag.
REQ-009 SHALL have port pwm_out  output  1  registered PWM bit to the output pin or filter.
REQ-010 SHALL have port period_tick  output  1  one-cycle pulse marking the first cycle of each PWM period.
REQ-011 SHALL have port underrun  output  1  sticky flag: a period began with no new sample.

Function
REQ-012 SHALL hold a WIDTH-bit period counter cnt that increments by 1 on each cycle with en=1, wraps from 2^WIDTH-1 to 0, and holds while en=0.
REQ-013 SHALL hold a WIDTH-bit shadow register and a full flag; sample_ready SHALL equal !full && !rst.
REQ-014 SHALL transfer a sample when sample_valid && sample_ready: shadow <= sample_in, full <= 1; sample_valid while sample_ready=0 SHALL be ignored.
REQ-015 SHALL define a boundary cycle as en=1 && cnt=2^WIDTH-1.
REQ-016 On a boundary with full=1, SHALL load active <= shadow and clear full.
REQ-017 On a boundary with full=0 and a simultaneous transfer, SHALL load active <= sample_in directly and keep full=0, with no underrun.
REQ-018 On a boundary with full=0 and no transfer, SHALL hold active and set underrun.
REQ-019 active SHALL change only on boundary cycles, so that no PWM period mixes two duty values.
REQ-020 On each en=1 cycle, SHALL register pwm_out <= (cnt < active), an unsigned compare; pwm_out therefore lags cnt by 1 cycle.
REQ-021 The duty cycle SHALL be exactly active/2^WIDTH: active=0 gives constant 0; active=2^WIDTH-1 gives 1 for 255 of 256 cycles (WIDTH=8).
REQ-022 On each en=0 cycle, SHALL register pwm_out <= 0, hold cnt and active, and still accept transfers per REQ-014.
REQ-023 SHALL register period_tick <= 1 on the cycle after each boundary (when cnt reads 0), and 0 otherwise.
REQ-024 SHALL clear underrun on underrun_clr; when set and clear coincide, set SHALL win.
REQ-025 Deasserting en mid-period SHALL freeze cnt; reasserting en SHALL resume the count from the frozen value.

Reset
REQ-026 While rst=1, SHALL force on every clock: cnt=0, shadow=0, active=0, full=0, pwm_out=0, period_tick=0, underrun=0; sample_ready SHALL be 0 while rst=1.
REQ-027 rst SHALL take priority over en, sample_valid and underrun_clr, including when asserted mid-period; the first boundary after release SHALL occur 2^WIDTH-1 enabled cycles after release.

Verification
REQ-028 Steady stream: WIDTH=8, en=1, one sample 64 offered per period -> pwm_out high 64 of every 256 cycles; underrun stays 0; period_tick pulses every 256 cycles.
REQ-029 Extremes: active=0 -> pwm_out constantly 0; active=255 -> pwm_out low exactly 1 cycle per period.
REQ-030 Underrun: after a period with active=100, no further samples -> active stays 100 and underrun=1 from the boundary; then underrun_clr=1 together with a new underrun -> underrun remains 1.
REQ-031 Back-pressure: full=1 with shadow=10, then sample_valid with 20 -> sample_ready=0, 20 dropped, the next period uses 10.
REQ-032 Boundary bypass: full=0 with sample_valid=1, sample_in=200 on the cycle cnt=255 -> the next period has 200 high cycles and underrun=0.
REQ-033 Enable and reset mid-period: en=0 at cnt=37 for 10 cycles -> pwm_out=0 and cnt=37 held, then the count resumes at 37; rst pulse at cnt=120 -> all outputs 0, and after release the first period_tick arrives 256 cycles after release.
